// File: rtl/ftdi_pkt_loader_pkg.sv
// Shared constants and state encodings for the FT245 packet loader.
package ftdi_pkt_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    typedef enum logic [2:0] {
        StIdle,
        StRdLo,
        StRdHi,
        StDispatch,
        StTxWait,
        StTxSetup,
        StTxWr,
        StTxHold
    } state_t;

    typedef enum logic [1:0] {
        PhSync,
        PhCmd,
        PhPayload,
        PhCsum
    } phase_t;

endpackage

// File: rtl/ftdi_pkt_loader_sync.sv
// Two-flop synchroniser for the FT245 status flags; resets to the inactive (high) level.
module ftdi_pkt_loader_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic s1_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b1;
            q    <= 1'b1;
        end else begin
            s1_q <= d;
            q    <= s1_q;
        end
    end

endmodule

// File: rtl/ftdi_pkt_loader.sv
// Reads framed programming packets from an FT245 async FIFO into a word buffer,
// replies ACK/NAK, and holds the buffer for UFMwrite until it signals consumed.
module ftdi_pkt_loader
    import ftdi_pkt_loader_pkg::*;
#(
    parameter int unsigned NWORDS  = 6,
    parameter int unsigned RD_LOW  = 3,
    parameter int unsigned RD_HIGH = 3,
    parameter int unsigned WR_LOW  = 3,
    parameter int unsigned TIMEOUT = 2500000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        rxf_n,
    input  logic        txe_n,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        rd_n,
    output logic        wr_n,
    output logic        siwu,
    output logic        oe_n,
    input  logic [2:0]  word_idx,
    output logic [31:0] word_data,
    output logic        dataready,
    input  logic        consumed,
    output logic [7:0]  err_count
);

    localparam int unsigned NBYTES = 4 * NWORDS;

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] to_cnt_q, to_cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic [7:0]  sum_q, sum_d;
    logic [5:0]  k_q, k_d;
    logic        nak_q, nak_d;
    logic        abort_q, abort_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic        data_oe_q, data_oe_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        dataready_q, dataready_d;
    logic [7:0]  err_q, err_d;
    logic        buf_we;
    logic        err_inc;
    logic        set_ready;
    logic [31:0] buf_q [NWORDS];
    logic        rxf_s, txe_s;

    ftdi_pkt_loader_sync u_sync_rxf (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rxf_n),
        .q       (rxf_s)
    );

    ftdi_pkt_loader_sync u_sync_txe (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (txe_n),
        .q       (txe_s)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        to_cnt_d    = to_cnt_q;
        byte_d      = byte_q;
        sum_d       = sum_q;
        k_d         = k_q;
        nak_d       = nak_q;
        abort_d     = abort_q;
        rd_n_d      = rd_n_q;
        wr_n_d      = wr_n_q;
        data_oe_d   = data_oe_q;
        data_out_d  = data_out_q;
        dataready_d = dataready_q;
        err_d       = err_q;
        buf_we      = 1'b0;
        err_inc     = 1'b0;
        set_ready   = 1'b0;

        case (state_q)
            StIdle: begin
                if (!rxf_s && enable && !dataready_q) begin
                    state_d  = StRdLo;
                    rd_n_d   = 1'b0;
                    cnt_d    = '0;
                    abort_d  = 1'b0;
                    to_cnt_d = '0;
                end else if (phase_q != PhSync) begin
                    // Inter-byte silence inside a packet drops it without a reply.
                    if (to_cnt_q >= TIMEOUT - 1) begin
                        phase_d  = PhSync;
                        err_inc  = 1'b1;
                        to_cnt_d = '0;
                    end else begin
                        to_cnt_d = to_cnt_q + 32'd1;
                    end
                end
            end
            StRdLo: begin
                if (!enable) abort_d = 1'b1;
                if (cnt_q == 8'(RD_LOW - 1)) begin
                    byte_d  = data_in;
                    rd_n_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = StRdHi;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StRdHi: begin
                if (!enable) abort_d = 1'b1;
                if (cnt_q == 8'(RD_HIGH - 1)) begin
                    state_d = StDispatch;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDispatch: begin
                state_d = StIdle;
                if (abort_q || !enable) begin
                    phase_d = PhSync;
                end else begin
                    case (phase_q)
                        PhSync: begin
                            if (byte_q == SYNC_BYTE) phase_d = PhCmd;
                        end
                        PhCmd: begin
                            if (byte_q == CMD_WRITE) begin
                                sum_d   = CMD_WRITE;
                                k_d     = '0;
                                phase_d = PhPayload;
                            end else begin
                                nak_d   = 1'b1;
                                state_d = StTxWait;
                            end
                        end
                        PhPayload: begin
                            buf_we = 1'b1;
                            sum_d  = sum_q + byte_q;
                            k_d    = k_q + 6'd1;
                            if (k_q == 6'(NBYTES - 1)) phase_d = PhCsum;
                        end
                        PhCsum: begin
                            nak_d   = (sum_q != byte_q);
                            state_d = StTxWait;
                        end
                        default: phase_d = PhSync;
                    endcase
                end
            end
            StTxWait: begin
                if (!txe_s) begin
                    data_out_d = nak_q ? NAK_BYTE : ACK_BYTE;
                    data_oe_d  = 1'b1;
                    state_d    = StTxSetup;
                    err_inc    = nak_q;
                    set_ready  = !nak_q;
                end
            end
            StTxSetup: begin
                wr_n_d  = 1'b0;
                cnt_d   = '0;
                state_d = StTxWr;
            end
            StTxWr: begin
                if (cnt_q == 8'(WR_LOW - 1)) begin
                    wr_n_d  = 1'b1;
                    state_d = StTxHold;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StTxHold: begin
                data_oe_d = 1'b0;
                nak_d     = 1'b0;
                phase_d   = PhSync;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A set on ACK beats a coincident consumed pulse.
        if (set_ready) begin
            dataready_d = 1'b1;
        end else if (consumed) begin
            dataready_d = 1'b0;
        end

        if (err_inc && err_q != 8'hFF) err_d = err_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            phase_q     <= PhSync;
            cnt_q       <= '0;
            to_cnt_q    <= '0;
            byte_q      <= '0;
            sum_q       <= '0;
            k_q         <= '0;
            nak_q       <= 1'b0;
            abort_q     <= 1'b0;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            data_oe_q   <= 1'b0;
            data_out_q  <= '0;
            dataready_q <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            to_cnt_q    <= to_cnt_d;
            byte_q      <= byte_d;
            sum_q       <= sum_d;
            k_q         <= k_d;
            nak_q       <= nak_d;
            abort_q     <= abort_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            data_oe_q   <= data_oe_d;
            data_out_q  <= data_out_d;
            dataready_q <= dataready_d;
            err_q       <= err_d;
        end
    end

    // Little-endian packing: payload byte k lands in word k/4, lane k%4.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < NWORDS; w++) buf_q[w] <= '0;
        end else if (buf_we) begin
            for (int w = 0; w < NWORDS; w++) begin
                if (k_q[5:2] == 4'(w)) buf_q[w][{k_q[1:0], 3'b000} +: 8] <= byte_q;
            end
        end
    end

    assign word_data = (32'(word_idx) < NWORDS) ? buf_q[word_idx] : '0;
    assign data_out  = data_out_q;
    assign data_oe   = data_oe_q;
    assign rd_n      = rd_n_q;
    assign wr_n      = wr_n_q;
    assign dataready = dataready_q;
    assign err_count = err_q;
    assign siwu      = 1'b1;
    assign oe_n      = 1'b1;

endmodule

// File: tb/tb_ftdi_pkt_loader.sv
// Bench for ftdi_pkt_loader: FT245 FIFO/host model plus a packet-level reference model.
module tb_ftdi_pkt_loader;

    localparam int NW  = 6;
    localparam int RDL = 3;
    localparam int WRL = 3;
    localparam int TO  = 300;

    logic        clk, reset_n, enable, rxf_n, txe_n, consumed;
    logic [7:0]  data_in, data_out, err_count;
    logic        data_oe, rd_n, wr_n, siwu, oe_n, dataready;
    logic [2:0]  word_idx;
    logic [31:0] word_data;

    ftdi_pkt_loader #(
        .NWORDS  (NW),
        .RD_LOW  (RDL),
        .RD_HIGH (3),
        .WR_LOW  (WRL),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .rxf_n     (rxf_n),
        .txe_n     (txe_n),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .rd_n      (rd_n),
        .wr_n      (wr_n),
        .siwu      (siwu),
        .oe_n      (oe_n),
        .word_idx  (word_idx),
        .word_data (word_data),
        .dataready (dataready),
        .consumed  (consumed),
        .err_count (err_count)
    );

    int total = 0;
    int bad   = 0;
    int exp_err = 0;

    logic [7:0]  rx_q [$];
    logic [7:0]  tx_q [$];
    logic [7:0]  pkt  [$];
    logic [31:0] m_words [8];

    int rd_cnt = 0, rd_len = 0, rd_len_bad = 0;
    int wr_len = 0, wr_len_bad = 0, oe_bad = 0;
    bit in_read = 0, in_wr = 0;

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    // FT245 receive side: byte presented while RD# low, popped when RD# rises.
    initial begin
        rxf_n   = 1'b1;
        data_in = 8'h00;
        forever begin
            @(negedge clk);
            if (!rd_n) begin
                if (!in_read) begin
                    in_read = 1;
                    rd_cnt++;
                    rd_len = 0;
                end
                rd_len++;
            end else if (in_read) begin
                in_read = 0;
                if (reset_n && rd_len != RDL) rd_len_bad++;
                if (rx_q.size() > 0) void'(rx_q.pop_front());
            end
            rxf_n   = (rx_q.size() == 0) || in_read;
            data_in = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        end
    end

    // FT245 transmit side: capture the reply byte on each WR# pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (!wr_n) begin
                if (!in_wr) begin
                    in_wr = 1;
                    tx_q.push_back(data_out);
                    wr_len = 0;
                end
                wr_len++;
                if (!data_oe) oe_bad++;
            end else if (in_wr) begin
                in_wr = 0;
                if (wr_len != WRL) wr_len_bad++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Packet-level reference: returns reply byte, or -1 when no reply is due.
    function automatic int model();
        int i = 0;
        logic [7:0] sum;
        for (int w = 0; w < 8; w++) m_words[w] = '0;
        while (i < pkt.size() && pkt[i] != 8'hA5) i++;
        i++;
        if (i >= pkt.size()) return -1;
        if (pkt[i] != 8'h57) return 32'h15;
        sum = pkt[i];
        i++;
        for (int k = 0; k < 4 * NW; k++) begin
            if (i >= pkt.size()) return -1;
            m_words[k / 4] = m_words[k / 4] | (32'(pkt[i]) << (8 * (k % 4)));
            sum = 8'(sum + pkt[i]);
            i++;
        end
        if (i >= pkt.size()) return -1;
        return (pkt[i] == sum) ? 32'h06 : 32'h15;
    endfunction

    task automatic make_pkt(input int junk, input bit seq, input bit good);
        logic [7:0] s, b, j;
        pkt.delete();
        for (int n = 0; n < junk; n++) begin
            j = 8'($urandom_range(0, 255));
            if (j == 8'hA5) j = 8'h00;
            pkt.push_back(j);
        end
        pkt.push_back(8'hA5);
        pkt.push_back(8'h57);
        s = 8'h57;
        for (int k = 0; k < 4 * NW; k++) begin
            b = seq ? 8'(k) : 8'($urandom_range(0, 255));
            pkt.push_back(b);
            s = 8'(s + b);
        end
        if (!good) s = s ^ 8'($urandom_range(1, 255));
        pkt.push_back(s);
    endtask

    task automatic push_pkt();
        foreach (pkt[n]) rx_q.push_back(pkt[n]);
    endtask

    task automatic pulse_consume(input string tag);
        @(negedge clk);
        consumed = 1'b1;
        @(negedge clk);
        consumed = 1'b0;
        chk({tag, "_consumed"}, 32'(dataready), 32'd0);
    endtask

    task automatic check_reply(input string tag, input bit consume);
        int rep;
        logic [7:0] b;
        bit got;
        rep = model();
        got = 0;
        b = 8'h00;
        for (int c = 0; c < 3000 && tx_q.size() == 0; c++) @(negedge clk);
        if (tx_q.size() > 0) begin
            got = 1;
            b = tx_q.pop_front();
        end
        for (int c = 0; c < 20 && data_oe; c++) @(negedge clk);
        chk({tag, "_got"}, 32'(got), 32'd1);
        chk({tag, "_reply"}, 32'(b), 32'(rep));
        chk({tag, "_oe_low"}, 32'(data_oe), 32'd0);
        if (rep == 32'h15 && exp_err < 255) exp_err++;
        chk({tag, "_ready"}, 32'(dataready), 32'(rep == 32'h06));
        chk({tag, "_err"}, 32'(err_count), 32'(exp_err));
        if (rep == 32'h06) begin
            for (int i = 0; i < 8; i++) begin
                word_idx = 3'(i);
                #1;
                chk($sformatf("%s_word%0d", tag, i), word_data, (i < NW) ? m_words[i] : 32'd0);
            end
            if (consume) pulse_consume(tag);
        end
    endtask

    task automatic run_pkt(input string tag, input bit consume);
        push_pkt();
        check_reply(tag, consume);
    endtask

    task automatic drain(input string tag);
        int c = 0;
        while (c < 2000 && !(rx_q.size() == 0 && rd_n)) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_drain_in_time"}, 32'(c < 2000), 32'd1);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int base;
        int c;
        reset_n  = 1'b0;
        enable   = 1'b0;
        txe_n    = 1'b0;
        consumed = 1'b0;
        word_idx = 3'd0;
        repeat (3) @(negedge clk);

        chk("rst_rd_n", 32'(rd_n), 32'd1);
        chk("rst_wr_n", 32'(wr_n), 32'd1);
        chk("rst_data_oe", 32'(data_oe), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_dataready", 32'(dataready), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_siwu", 32'(siwu), 32'd1);
        chk("rst_oe_n", 32'(oe_n), 32'd1);
        chk("rst_word0", word_data, 32'd0);

        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (4) @(negedge clk);

        // Sequential payload, kept unconsumed for the lock check.
        make_pkt(0, 1, 1);
        run_pkt("ack1", 0);
        word_idx = 3'd0;
        #1 chk("ack1_w0_const", word_data, 32'h03020100);
        word_idx = 3'd5;
        #1 chk("ack1_w5_const", word_data, 32'h17161514);

        // Buffer lock: no reads while dataready is held.
        base = rd_cnt;
        push_pkt();
        repeat (60) @(negedge clk);
        chk("lock_no_reads", 32'(rd_cnt - base), 32'd0);
        chk("lock_rd_n", 32'(rd_n), 32'd1);
        chk("lock_fifo_full", 32'(rx_q.size()), 32'(pkt.size()));
        pulse_consume("lock");
        check_reply("lock_next", 1);

        make_pkt(0, 1, 0);
        run_pkt("nak_csum", 1);

        make_pkt(0, 1, 1);
        pkt.push_front(8'hFF);
        pkt.push_front(8'h00);
        run_pkt("junk_ack", 1);

        pkt.delete();
        pkt.push_back(8'hA5);
        pkt.push_back(8'h3C);
        run_pkt("nak_cmd", 1);

        for (int r = 0; r < 6; r++) begin
            make_pkt($urandom_range(0, 3), 0, ($urandom_range(0, 1) == 1));
            run_pkt($sformatf("rnd%0d", r), 1);
        end

        // Inter-byte timeout in PAYLOAD.
        pkt.delete();
        pkt.push_back(8'hA5);
        pkt.push_back(8'h57);
        for (int k = 0; k < 10; k++) pkt.push_back(8'($urandom_range(0, 255)));
        push_pkt();
        drain("to");
        repeat (TO - 80) @(negedge clk);
        chk("to_before_limit", 32'(err_count), 32'(exp_err));
        repeat (120) @(negedge clk);
        exp_err++;
        chk("to_after_limit", 32'(err_count), 32'(exp_err));
        chk("to_no_reply", 32'(tx_q.size()), 32'd0);
        make_pkt(0, 0, 1);
        run_pkt("to_recover", 1);

        // enable drops during the third read: silent abort, no error count.
        pkt.delete();
        pkt.push_back(8'hA5);
        pkt.push_back(8'h57);
        pkt.push_back(8'h00);
        pkt.push_back(8'h01);
        base = rd_cnt;
        push_pkt();
        c = 0;
        while (c < 500 && !(rd_cnt >= base + 3 && !rd_n)) begin
            @(negedge clk);
            c++;
        end
        chk("en_reached_read", 32'(c < 500), 32'd1);
        enable = 1'b0;
        repeat (20) @(negedge clk);
        enable = 1'b1;
        drain("en");
        chk("en_no_reply", 32'(tx_q.size()), 32'd0);
        chk("en_err", 32'(err_count), 32'(exp_err));
        make_pkt(0, 0, 1);
        run_pkt("en_recover", 1);

        // Async reset while RD# is low in PAYLOAD.
        make_pkt(0, 0, 1);
        base = rd_cnt;
        push_pkt();
        c = 0;
        while (c < 500 && !(rd_cnt >= base + 8 && !rd_n)) begin
            @(negedge clk);
            c++;
        end
        chk("rst_mid_reached", 32'(c < 500), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_rd_n", 32'(rd_n), 32'd1);
        chk("rst_mid_oe", 32'(data_oe), 32'd0);
        chk("rst_mid_ready", 32'(dataready), 32'd0);
        chk("rst_mid_err", 32'(err_count), 32'd0);
        exp_err = 0;
        repeat (2) @(negedge clk);
        rx_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        make_pkt(1, 0, 1);
        run_pkt("rst_recover", 1);

        chk("rd_pulse_width", 32'(rd_len_bad), 32'd0);
        chk("wr_pulse_width", 32'(wr_len_bad), 32'd0);
        chk("oe_during_wr", 32'(oe_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
